// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard-control bundle between the 5-stage pipeline datapath and the hazard controller.
// The controller takes the slave view; the datapath (or a bench) drives through the master view.
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned MISSW = 16
);
    // Register specifiers per stage
    logic [4:0]       Rs1D;
    logic [4:0]       Rs2D;
    logic [4:0]       Rs1E;
    logic [4:0]       Rs2E;
    logic [4:0]       RdE;
    logic [4:0]       RdM;
    logic [4:0]       RdW;
    // Pipeline status
    logic             ResultSrcE;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             PCSrcE;
    // D-cache refill handshake
    logic             MissM;
    logic             RefillAck;
    logic             RefillDone;
    logic             RefillReq;
    // Pipeline register control
    logic             StallF;
    logic             StallD;
    logic             StallE;
    logic             StallM;
    logic             StallW;
    logic             FlushD;
    logic             FlushE;
    logic [1:0]       ForwardAE;
    logic [1:0]       ForwardBE;
    // Performance counters
    logic [WIDTH-1:0] StallCycles;
    logic [MISSW-1:0] MissCount;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        output ResultSrcE, RegWriteM, RegWriteW, PCSrcE,
        output MissM, RefillAck, RefillDone,
        input  RefillReq,
        input  StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        input  ForwardAE, ForwardBE,
        input  StallCycles, MissCount
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW,
        input  ResultSrcE, RegWriteM, RegWriteW, PCSrcE,
        input  MissM, RefillAck, RefillDone,
        output RefillReq,
        output StallF, StallD, StallE, StallM, StallW, FlushD, FlushE,
        output ForwardAE, ForwardBE,
        output StallCycles, MissCount
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard controller for the 5-stage RV32I pipeline: E-stage forwarding, load-use
// stall, branch flush, D-cache miss refill sequencing, and saturating stall/miss counters.
module pipeline_hazard_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned MISSW = 16
) (
    input logic                   clk,
    input logic                   rst,
    pipeline_hazard_ctrl_if.slave hz_io
);

    typedef enum logic [1:0] {StIdle, StReq, StWait, StResume} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [MISSW-1:0] miss_cnt_q, miss_cnt_d;

    logic       load_use;
    logic       freeze;
    logic       miss_accept;
    logic       stall_f, stall_d, stall_e, stall_m, stall_w;
    logic       flush_d, flush_e;
    logic [1:0] fwd_a, fwd_b;

    // M-stage result wins over W-stage; x0 is never forwarded
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic wr_m,
                                           input logic [4:0] rd_m, input logic wr_w,
                                           input logic [4:0] rd_w);
        if (wr_m && (rd_m != 5'd0) && (rd_m == rs)) begin
            return 2'b10;
        end else if (wr_w && (rd_w != 5'd0) && (rd_w == rs)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    assign load_use = hz_io.ResultSrcE && (hz_io.RdE != 5'd0) &&
                      ((hz_io.RdE == hz_io.Rs1D) || (hz_io.RdE == hz_io.Rs2D));
    // A miss seen in IDLE freezes the pipeline in that same cycle
    assign freeze      = (state_q != StIdle) || hz_io.MissM;
    assign miss_accept = (state_q == StIdle) && hz_io.MissM;

    // State and counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            stall_cnt_q <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    // Refill sequencing; stray Ack/Done outside their state are ignored
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:   if (hz_io.MissM)      state_d = StReq;
            StReq:    if (hz_io.RefillAck)  state_d = StWait;
            StWait:   if (hz_io.RefillDone) state_d = StResume;
            StResume: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Stall/flush priority: reset, then freeze, then branch, then load-use
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        stall_w = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        if (rst) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (freeze) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            stall_w = 1'b1;
        end else if (hz_io.PCSrcE) begin
            // The load-dependent instruction is squashed, so no load-use stall is needed
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    // Forwarding selects for both E-stage operands
    always_comb begin
        fwd_a = 2'b00;
        fwd_b = 2'b00;
        if (!rst) begin
            fwd_a = fwd_sel(hz_io.Rs1E, hz_io.RegWriteM, hz_io.RdM, hz_io.RegWriteW, hz_io.RdW);
            fwd_b = fwd_sel(hz_io.Rs2E, hz_io.RegWriteM, hz_io.RdM, hz_io.RegWriteW, hz_io.RdW);
        end
    end

    // Saturating performance counters
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + WIDTH'(1);
        end
        if (miss_accept && (miss_cnt_q != '1)) begin
            miss_cnt_d = miss_cnt_q + MISSW'(1);
        end
    end

    assign hz_io.StallF      = stall_f;
    assign hz_io.StallD      = stall_d;
    assign hz_io.StallE      = stall_e;
    assign hz_io.StallM      = stall_m;
    assign hz_io.StallW      = stall_w;
    assign hz_io.FlushD      = flush_d;
    assign hz_io.FlushE      = flush_e;
    assign hz_io.ForwardAE   = fwd_a;
    assign hz_io.ForwardBE   = fwd_b;
    assign hz_io.RefillReq   = (state_q == StReq) && !rst;
    assign hz_io.StallCycles = stall_cnt_q;
    assign hz_io.MissCount   = miss_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl with a narrow stall counter to reach saturation.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned W  = 4;
    localparam int unsigned MW = 16;

    typedef struct packed {
        logic [4:0]    stall;   // {F,D,E,M,W}
        logic [1:0]    flush;   // {D,E}
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          req;
        logic [W-1:0]  sc;
        logic [MW-1:0] mc;
    } exp_t;

    logic clk = 1'b0;
    logic rst;

    pipeline_hazard_ctrl_if #(.WIDTH(W), .MISSW(MW)) hz ();

    pipeline_hazard_ctrl #(.WIDTH(W), .MISSW(MW)) dut (
        .clk   (clk),
        .rst   (rst),
        .hz_io (hz.slave)
    );

    always #5 clk = ~clk;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    // Reference model state: 0=idle 1=req 2=wait 3=resume
    int m_st = 0;
    int m_sc = 0;
    int m_mc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (hz.RegWriteM && hz.RdM != 0 && hz.RdM == rs) return 2'b10;
        if (hz.RegWriteW && hz.RdW != 0 && hz.RdW == rs) return 2'b01;
        return 2'b00;
    endfunction

    function automatic exp_t predict();
        exp_t e;
        logic lu;
        e       = '0;
        e.sc    = W'(m_sc);
        e.mc    = MW'(m_mc);
        lu      = hz.ResultSrcE && hz.RdE != 0 && (hz.RdE == hz.Rs1D || hz.RdE == hz.Rs2D);
        if (rst) begin
            e.flush = 2'b11;
        end else begin
            e.fa  = ref_fwd(hz.Rs1E);
            e.fb  = ref_fwd(hz.Rs2E);
            e.req = (m_st == 1);
            if (m_st != 0 || hz.MissM) e.stall = 5'b11111;
            else if (hz.PCSrcE)        e.flush = 2'b11;
            else if (lu) begin
                e.stall = 5'b11000;
                e.flush = 2'b01;
            end
        end
        return e;
    endfunction

    // Advance the model across the coming rising edge
    task automatic model_edge(input exp_t e);
        if (rst) begin
            m_st = 0;
            m_sc = 0;
            m_mc = 0;
        end else begin
            if (e.stall[4] && m_sc < (1 << W) - 1) m_sc++;
            case (m_st)
                0: if (hz.MissM) begin
                    m_st = 1;
                    if (m_mc < (1 << MW) - 1) m_mc++;
                end
                1: if (hz.RefillAck)  m_st = 2;
                2: if (hz.RefillDone) m_st = 3;
                default: m_st = 0;
            endcase
        end
    endtask

    // Called at a negedge with inputs already applied; returns at the next negedge
    task automatic step();
        exp_t e;
        e = predict();
        sb_q.push_back(e);
        #2;
        e = sb_q.pop_front();
        check_eq("stall", {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.StallW}, e.stall);
        check_eq("flush", {hz.FlushD, hz.FlushE}, e.flush);
        check_eq("fwdA", hz.ForwardAE, e.fa);
        check_eq("fwdB", hz.ForwardBE, e.fb);
        check_eq("req", hz.RefillReq, e.req);
        check_eq("stall_cnt", hz.StallCycles, e.sc);
        check_eq("miss_cnt", hz.MissCount, e.mc);
        model_edge(e);
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        rst = 1'b0;
        {hz.Rs1D, hz.Rs2D, hz.Rs1E, hz.Rs2E, hz.RdE, hz.RdM, hz.RdW} = '0;
        {hz.ResultSrcE, hz.RegWriteM, hz.RegWriteW, hz.PCSrcE} = '0;
        {hz.MissM, hz.RefillAck, hz.RefillDone} = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b1;
        @(negedge clk);
        step();
        rst = 1'b0;
        check_eq("rst_sc", hz.StallCycles, 0);
        check_eq("rst_mc", hz.MissCount, 0);
        check_eq("rst_req", hz.RefillReq, 0);

        // Load-use: one stall cycle, then forwarding from M
        hz.ResultSrcE = 1'b1; hz.RdE = 5'd5; hz.Rs1D = 5'd5;
        step();
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.RdM = 5'd5; hz.Rs1E = 5'd5;
        step();
        check_eq("lu_fwdA", hz.ForwardAE, 2'b10);
        check_eq("lu_stall_cnt", hz.StallCycles, 1);
        clear_inputs();
        step();

        // Branch beats load-use; forwarding priority and x0
        hz.ResultSrcE = 1'b1; hz.RdE = 5'd3; hz.Rs2D = 5'd3; hz.PCSrcE = 1'b1;
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1; hz.RdM = 5'd7; hz.RdW = 5'd7; hz.Rs2E = 5'd7;
        step();
        check_eq("br_fwdB", hz.ForwardBE, 2'b10);
        check_eq("br_flush", {hz.FlushD, hz.FlushE, hz.StallF, hz.StallD}, 4'b1100);
        clear_inputs();
        hz.RegWriteM = 1'b1; hz.RegWriteW = 1'b1;
        step();
        hz.RegWriteM = 1'b0; hz.RdW = 5'd9; hz.Rs1E = 5'd9;
        step();
        clear_inputs();

        // Miss sequence: Miss T0, Ack T3, Done T6
        do_reset();
        for (int t = 0; t <= 8; t++) begin
            clear_inputs();
            hz.MissM      = (t == 0);
            hz.RefillAck  = (t == 3);
            hz.RefillDone = (t == 6);
            if (t == 8) begin
                #2;
                check_eq("miss_release", hz.StallF, 0);
                check_eq("miss_sc", hz.StallCycles, 8);
                check_eq("miss_mc", hz.MissCount, 1);
                #(-0);
            end
            step();
        end

        // Miss together with a branch: freeze wins
        clear_inputs();
        hz.MissM = 1'b1; hz.PCSrcE = 1'b1;
        step();
        clear_inputs();
        step();
        hz.RefillAck = 1'b1;
        step();
        clear_inputs();

        // Reset in WAIT abandons the refill, then a new miss restarts at REQ
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rmid_sc", hz.StallCycles, 0);
        check_eq("rmid_mc", hz.MissCount, 0);
        hz.MissM = 1'b1;
        step();
        clear_inputs();
        check_eq("rmid_req", hz.RefillReq, 1);
        hz.RefillAck = 1'b1;
        step();
        clear_inputs();
        hz.RefillDone = 1'b1;
        step();
        clear_inputs();
        step();
        step();

        // Saturation and back-to-back misses
        do_reset();
        hz.MissM = 1'b1;
        step();
        clear_inputs();
        for (int i = 0; i < 16; i++) step();
        hz.RefillAck = 1'b1;
        step();
        clear_inputs();
        hz.RefillDone = 1'b1;
        step();
        clear_inputs();
        step();                      // RESUME; MissM low here
        check_eq("sat_sc", hz.StallCycles, 15);
        hz.MissM = 1'b1;             // IDLE cycle right after RESUME
        step();
        clear_inputs();
        check_eq("b2b_mc", hz.MissCount, 2);
        check_eq("b2b_req", hz.RefillReq, 1);
        hz.RefillAck = 1'b1;
        step();
        clear_inputs();
        hz.RefillDone = 1'b1;
        step();
        clear_inputs();
        step();

        // Randomised traffic against the model
        do_reset();
        for (int i = 0; i < 300; i++) begin
            rst           = ($urandom_range(0, 39) == 0);
            hz.Rs1D       = 5'($urandom_range(0, 7));
            hz.Rs2D       = 5'($urandom_range(0, 7));
            hz.Rs1E       = 5'($urandom_range(0, 7));
            hz.Rs2E       = 5'($urandom_range(0, 7));
            hz.RdE        = 5'($urandom_range(0, 7));
            hz.RdM        = 5'($urandom_range(0, 7));
            hz.RdW        = 5'($urandom_range(0, 7));
            hz.ResultSrcE = 1'($urandom_range(0, 1));
            hz.RegWriteM  = 1'($urandom_range(0, 1));
            hz.RegWriteW  = 1'($urandom_range(0, 1));
            hz.PCSrcE     = ($urandom_range(0, 4) == 0);
            hz.MissM      = ($urandom_range(0, 7) == 0);
            hz.RefillAck  = ($urandom_range(0, 2) == 0);
            hz.RefillDone = ($urandom_range(0, 3) == 0);
            step();
        end

        check_eq("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
